tnkiii_rotary_ctrl: RTL and testbench
=====================================

// Module: tnkiii_rotary_ctrl
// PURPOSE
//  Sequences the two 12-position rotary joysticks feeding PLAYER1/PLAYER2[7:4].
//  Converts held rotate-left/right buttons into position steps: one immediate step
//  on press, then auto-repeat after a hold delay. Sits between the joystick decode
//  and the TNKIIICore input words; honours the global pause.
// PARAMETERS
//  POSITIONS     12     number of rotary positions; position range 0..POSITIONS-1
//  INIT_P1       11     player-1 position after reset
//  INIT_P2       0      player-2 position after reset
//  TICK_DIV      53600  i_clk cycles per timing tick (1 ms at 53.6 MHz)
//  DELAY_TICKS   250    ticks from first step to first auto-repeat step
//  REPEAT_TICKS  80     ticks between auto-repeat steps
// PORTS
//  i_clk      in   1  system clock, 53.6 MHz
//  RESETn     in   1  asynchronous active-low reset
//  pause_cpu  in   1  1 = freeze all sequencing
//  rot_left   in   2  [0]=P1, [1]=P2; active-high rotate-left (increment) request
//  rot_right  in   2  [0]=P1, [1]=P2; active-high rotate-right (decrement) request
//  rotary1    out  4  player-1 position
//  rotary2    out  4  player-2 position
//  step       out  2  one-cycle pulse per player when its position changes
// BEHAVIOUR
//  Reset (RESETn=0, async): rotary1=INIT_P1, rotary2=INIT_P2, step=0, prescaler=0,
//   both channels in IDLE, prev_dir=NONE. All outputs are registered.
//  Prescaler: counts 0..TICK_DIV-1; tick=1 for one cycle at TICK_DIV-1, then wraps to 0.
//   Shared by both channels; holds its value while pause_cpu=1.
//  Direction decode per player: L only->LEFT, R only->RIGHT, both or none->NONE.
//  Step arithmetic: LEFT: pos==POSITIONS-1 ? 0 : pos+1. RIGHT: pos==0 ? POSITIONS-1 : pos-1.
//  Channel FSM (per player, 8-bit tick counter cnt):
//   IDLE:   dir!=NONE -> apply step at this edge, cnt=0, -> DELAY.
//   DELAY:  dir==NONE -> IDLE. dir!=prev_dir -> step in new dir, cnt=0, stay DELAY.
//           tick & cnt==DELAY_TICKS-1 -> step, cnt=0, -> REPEAT; else tick -> cnt+1.
//   REPEAT: dir==NONE -> IDLE. dir!=prev_dir -> step in new dir, cnt=0, -> DELAY.
//           tick & cnt==REPEAT_TICKS-1 -> step, cnt=0; else tick -> cnt+1.
//  Latency: a direction first visible at edge n updates position at edge n; new
//   value and step pulse readable in cycle n+1. step is 1 exactly in the cycle after
//   each position change, else 0.
//  Pause: while pause_cpu=1 state, cnt, positions, prev_dir and prescaler hold;
//   step forced 0. On release, decode compares against the held prev_dir, so a
//   press/release/reversal that occurred during pause is acted on in the first
//   unpaused cycle per the FSM rules above.
//  Simultaneous events: dir change and tick in one cycle -> dir change wins (one
//   step only). Both players stepping in the same cycle are independent.
//  Reset mid-hold: channel returns to IDLE with init position; a button still held
//   at reset release counts as a new press (one immediate step).
//  prev_dir updates every unpaused cycle to the current decoded dir.
// STRUCTURE
//  Package tnkiii_rotary_pkg: rot_dir_t {NONE,LEFT,RIGHT}; rot_state_t
//   {IDLE,DELAY,REPEAT}; function rot_step(pos,dir,positions) for wrap arithmetic.
//  Sub-module tnkiii_rotary_chan: one FSM + tick counter + position register,
//   parameterised by INIT; instantiated twice. Top holds prescaler and output wiring.
// TESTING (bench params: TICK_DIV=4, DELAY_TICKS=3, REPEAT_TICKS=2)
//  Reset: RESETn low -> rotary1=11, rotary2=0, step=00 immediately (async).
//  P1 left tap 1 cycle from pos 11 -> rotary1=0, step[0] single pulse, then IDLE.
//  P2 right held 40 cycles from 0 -> 11 at press, 10 after 12 cycles, then one
//   decrement every 8 cycles (9,8,7); release -> no further steps.
//  P1 left held, switch to right mid-REPEAT -> immediate decrement, new 12-cycle delay.
//  Left+right both held -> no step; release right -> one increment (treated as press).
//  pause_cpu=1 during DELAY for 50 cycles -> positions, step=0 frozen; after release
//   remaining delay ticks complete with no lost or extra step.

Source files
------------

// File: rtl/tnkiii_rotary_pkg.sv
// rtl/tnkiii_rotary_pkg.sv - shared types and wrap arithmetic for the rotary joystick sequencer
package tnkiii_rotary_pkg;

   typedef enum logic [1:0] {NONE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} rot_dir_t;
   typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} rot_state_t;

   function automatic rot_dir_t rot_decode(input logic left, input logic right);
      if (left && !right)
         return LEFT;
      else if (right && !left)
         return RIGHT;
      else
         return NONE;
   endfunction

   // LEFT increments and RIGHT decrements, both wrapping inside 0..positions-1.
   function automatic logic [3:0] rot_step(input logic [3:0] pos, input rot_dir_t dir,
                                           input int positions);
      logic [3:0] last;
      last = 4'(positions - 1);
      case (dir)
         LEFT:    return (pos == last) ? 4'd0 : pos + 4'd1;
         RIGHT:   return (pos == 4'd0) ? last : pos - 4'd1;
         default: return pos;
      endcase
   endfunction

endpackage

// File: rtl/tnkiii_rotary_ctrl_if.sv
// rtl/tnkiii_rotary_ctrl_if.sv - button requests in, rotary positions and step pulses out
interface tnkiii_rotary_ctrl_if;
   logic       pause_cpu;
   logic [1:0] rot_left;
   logic [1:0] rot_right;
   logic [3:0] rotary1;
   logic [3:0] rotary2;
   logic [1:0] step;

   modport master (output pause_cpu, rot_left, rot_right,
                   input  rotary1, rotary2, step);
   modport slave  (input  pause_cpu, rot_left, rot_right,
                   output rotary1, rotary2, step);
endinterface

// File: rtl/tnkiii_rotary_chan.sv
// rtl/tnkiii_rotary_chan.sv - one player: press/hold/repeat FSM, tick counter, position register
module tnkiii_rotary_chan
   import tnkiii_rotary_pkg::*;
#(
   parameter int POSITIONS    = 12,
   parameter int INIT         = 0,
   parameter int DELAY_TICKS  = 250,
   parameter int REPEAT_TICKS = 80
) (
   input  logic       i_clk,
   input  logic       RESETn,
   input  logic       pause,
   input  logic       tick,
   input  logic       left,
   input  logic       right,
   output logic [3:0] pos,
   output logic       step
);

   localparam logic [7:0] DLY_LAST = 8'(DELAY_TICKS - 1);
   localparam logic [7:0] REP_LAST = 8'(REPEAT_TICKS - 1);

   rot_state_t state, state_nxt;
   rot_dir_t   dir, prev_dir;
   logic [7:0] cnt, cnt_nxt;
   logic [3:0] pos_nxt;
   logic       do_step;

   assign dir = rot_decode(left, right);

   always_ff @(posedge i_clk or negedge RESETn) begin
      if (!RESETn) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         pos      <= 4'(INIT);
         prev_dir <= NONE;
         step     <= 1'b0;
      end else if (pause) begin
         step     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         pos      <= pos_nxt;
         prev_dir <= dir;
         step     <= do_step;
      end
   end

   // A direction change outranks a coincident tick, so at most one step per edge.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pos_nxt   = pos;
      do_step   = 1'b0;
      case (state)
         IDLE: begin
            if (dir != NONE) begin
               do_step   = 1'b1;
               cnt_nxt   = 8'd0;
               state_nxt = DELAY;
            end
         end
         DELAY, REPEAT: begin
            if (dir == NONE) begin
               cnt_nxt   = 8'd0;
               state_nxt = IDLE;
            end else if (dir != prev_dir) begin
               do_step   = 1'b1;
               cnt_nxt   = 8'd0;
               state_nxt = DELAY;
            end else if (tick) begin
               if (cnt == ((state == DELAY) ? DLY_LAST : REP_LAST)) begin
                  do_step   = 1'b1;
                  cnt_nxt   = 8'd0;
                  state_nxt = REPEAT;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (do_step)
         pos_nxt = rot_step(pos, dir, POSITIONS);
   end

endmodule

// File: rtl/tnkiii_rotary_ctrl.sv
// rtl/tnkiii_rotary_ctrl.sv - shared ms prescaler and the two rotary joystick channels
module tnkiii_rotary_ctrl
   import tnkiii_rotary_pkg::*;
#(
   parameter int POSITIONS    = 12,
   parameter int INIT_P1      = 11,
   parameter int INIT_P2      = 0,
   parameter int TICK_DIV     = 53600,
   parameter int DELAY_TICKS  = 250,
   parameter int REPEAT_TICKS = 80
) (
   input  logic               i_clk,
   input  logic               RESETn,
   tnkiii_rotary_ctrl_if.slave bus
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] presc;
   logic          tick;
   logic          step_p1, step_p2;

   assign tick = (presc == PW'(TICK_DIV - 1));

   always_ff @(posedge i_clk or negedge RESETn) begin
      if (!RESETn)
         presc <= '0;
      else if (!bus.pause_cpu)
         presc <= tick ? '0 : presc + PW'(1);
   end

   tnkiii_rotary_chan #(
      .POSITIONS(POSITIONS), .INIT(INIT_P1),
      .DELAY_TICKS(DELAY_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
   ) u_chan_p1 (
      .i_clk(i_clk), .RESETn(RESETn), .pause(bus.pause_cpu), .tick(tick),
      .left(bus.rot_left[0]), .right(bus.rot_right[0]),
      .pos(bus.rotary1), .step(step_p1)
   );

   tnkiii_rotary_chan #(
      .POSITIONS(POSITIONS), .INIT(INIT_P2),
      .DELAY_TICKS(DELAY_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
   ) u_chan_p2 (
      .i_clk(i_clk), .RESETn(RESETn), .pause(bus.pause_cpu), .tick(tick),
      .left(bus.rot_left[1]), .right(bus.rot_right[1]),
      .pos(bus.rotary2), .step(step_p2)
   );

   assign bus.step = {step_p2, step_p1};

endmodule

// File: tb/tb_tnkiii_rotary_ctrl.sv
// tb/tb_tnkiii_rotary_ctrl.sv - randomized and directed bench for tnkiii_rotary_ctrl
module tb_tnkiii_rotary_ctrl;

   localparam int POSITIONS    = 12;
   localparam int TICK_DIV     = 4;
   localparam int DELAY_TICKS  = 3;
   localparam int REPEAT_TICKS = 2;

   logic i_clk = 1'b0;
   logic RESETn = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   tnkiii_rotary_ctrl_if bus();

   tnkiii_rotary_ctrl #(
      .POSITIONS(POSITIONS), .INIT_P1(11), .INIT_P2(0), .TICK_DIV(TICK_DIV),
      .DELAY_TICKS(DELAY_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
   ) dut (
      .i_clk(i_clk), .RESETn(RESETn), .bus(bus)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: press steps at once, then every hold period counted in whole ticks.
   int       m_presc;
   int       m_pos   [2];
   int       m_prev  [2];
   bit       m_held  [2];
   bit       m_rep   [2];
   int       m_ticks [2];
   bit [1:0] m_step;

   wire [9:0] act = {bus.rotary1, bus.rotary2, bus.step};

   function automatic bit [9:0] exp_word();
      return {4'(m_pos[0]), 4'(m_pos[1]), m_step};
   endfunction

   function automatic int move(input int pos, input int d);
      return (d == 1) ? (pos + 1) % POSITIONS : (pos + POSITIONS - 1) % POSITIONS;
   endfunction

   task automatic model_reset();
      m_presc = 0;
      m_pos[0] = 11;
      m_pos[1] = 0;
      m_step = 2'b00;
      for (int p = 0; p < 2; p++) begin
         m_prev[p] = 0; m_held[p] = 0; m_rep[p] = 0; m_ticks[p] = 0;
      end
   endtask

   task automatic model_edge();
      int d;
      bit tk;
      if (!RESETn) begin
         model_reset();
         return;
      end
      if (bus.pause_cpu) begin
         m_step = 2'b00;
         return;
      end
      tk = (m_presc == TICK_DIV - 1);
      m_presc = (m_presc + 1) % TICK_DIV;
      for (int p = 0; p < 2; p++) begin
         d = (bus.rot_left[p] && !bus.rot_right[p]) ? 1 :
             (bus.rot_right[p] && !bus.rot_left[p]) ? 2 : 0;
         m_step[p] = 1'b0;
         if (d == 0) begin
            m_held[p] = 0;
         end else if (!m_held[p] || d != m_prev[p]) begin
            m_pos[p] = move(m_pos[p], d);
            m_held[p] = 1; m_rep[p] = 0; m_ticks[p] = 0; m_step[p] = 1'b1;
         end else if (tk) begin
            m_ticks[p]++;
            if (m_ticks[p] == (m_rep[p] ? REPEAT_TICKS : DELAY_TICKS)) begin
               m_pos[p] = move(m_pos[p], d);
               m_ticks[p] = 0; m_rep[p] = 1; m_step[p] = 1'b1;
            end
         end
         m_prev[p] = d;
      end
   endtask

   task automatic clk_step();
      @(posedge i_clk);
      model_edge();
      #1;
   endtask

   task automatic restart();
      bus.rot_left = 2'b00;
      bus.rot_right = 2'b00;
      bus.pause_cpu = 1'b0;
      RESETn = 1'b0;
      model_reset();
      clk_step();
      RESETn = 1'b1;
   endtask

   task automatic test_reset();
      restart();
      bus.rot_left = 2'b01;
      bus.rot_right = 2'b10;
      repeat (7) clk_step();
      #2;
      RESETn = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (act !== {4'd11, 4'd0, 2'b00}) begin
         miscompares++;
         $display("FAIL reset_async: got %h want %h", act, {4'd11, 4'd0, 2'b00});
      end
      clk_step();
      RESETn = 1'b1;
      bus.rot_left = 2'b00;
      bus.rot_right = 2'b00;
   endtask

   task automatic test_left_tap();
      int pulses = 0;
      restart();
      bus.rot_left = 2'b01;
      clk_step();
      vectors++;
      if (act !== {4'd0, 4'd0, 2'b01}) begin
         miscompares++;
         $display("FAIL tap_first_step: got %h want %h", act, {4'd0, 4'd0, 2'b01});
      end
      bus.rot_left = 2'b00;
      for (int i = 0; i < 20; i++) begin
         clk_step();
         pulses += int'(bus.step[0]);
         vectors++;
         if (act !== exp_word()) begin
            miscompares++;
            $display("FAIL tap_cycle%0d: got %h want %h", i, act, exp_word());
         end
      end
      vectors++;
      if (pulses != 0) begin
         miscompares++;
         $display("FAIL tap_extra_pulses: got %0d want 0", pulses);
      end
   endtask

   task automatic test_right_hold();
      int seen[$];
      int want[5] = '{11, 10, 9, 8, 7};
      restart();
      bus.rot_right = 2'b10;
      for (int i = 0; i < 60; i++) begin
         if (i == 40) bus.rot_right = 2'b00;
         clk_step();
         if (bus.step[1]) seen.push_back(int'(bus.rotary2));
         vectors++;
         if (act !== exp_word()) begin
            miscompares++;
            $display("FAIL hold_cycle%0d: got %h want %h", i, act, exp_word());
         end
      end
      vectors++;
      if (seen.size() != 5) begin
         miscompares++;
         $display("FAIL hold_step_count: got %0d want 5", seen.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            vectors++;
            if (seen[k] != want[k]) begin
               miscompares++;
               $display("FAIL hold_value%0d: got %0d want %0d", k, seen[k], want[k]);
            end
         end
      end
   endtask

   task automatic test_reversal();
      restart();
      bus.rot_left = 2'b01;
      for (int i = 0; i < 60; i++) begin
         if (i == 30) begin
            bus.rot_left = 2'b00;
            bus.rot_right = 2'b01;
         end
         clk_step();
         vectors++;
         if (act !== exp_word()) begin
            miscompares++;
            $display("FAIL reversal_cycle%0d: got %h want %h", i, act, exp_word());
         end
      end
   endtask

   task automatic test_both();
      restart();
      bus.rot_left = 2'b01;
      bus.rot_right = 2'b01;
      repeat (10) clk_step();
      vectors++;
      if (act !== {4'd11, 4'd0, 2'b00}) begin
         miscompares++;
         $display("FAIL both_no_step: got %h want %h", act, {4'd11, 4'd0, 2'b00});
      end
      bus.rot_right = 2'b00;
      clk_step();
      vectors++;
      if (act !== {4'd0, 4'd0, 2'b01}) begin
         miscompares++;
         $display("FAIL both_release_right: got %h want %h", act, {4'd0, 4'd0, 2'b01});
      end
      bus.rot_left = 2'b00;
      clk_step();
   endtask

   task automatic test_pause();
      restart();
      bus.rot_left = 2'b01;
      for (int i = 0; i < 100; i++) begin
         bus.pause_cpu = (i >= 5 && i < 55);
         clk_step();
         vectors++;
         if (act !== exp_word()) begin
            miscompares++;
            $display("FAIL pause_cycle%0d: got %h want %h", i, act, exp_word());
         end
      end
      bus.pause_cpu = 1'b0;
      bus.rot_left = 2'b00;
   endtask

   task automatic test_random();
      restart();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) bus.rot_left  = 2'($urandom);
         if ($urandom_range(0, 7) == 0) bus.rot_right = 2'($urandom);
         if ($urandom_range(0, 15) == 0) bus.pause_cpu = ~bus.pause_cpu;
         clk_step();
         vectors++;
         if (act !== exp_word()) begin
            miscompares++;
            $display("FAIL random_cycle%0d: got %h want %h", i, act, exp_word());
         end
      end
   endtask

   initial begin
      bus.pause_cpu = 1'b0;
      bus.rot_left = 2'b00;
      bus.rot_right = 2'b00;
      model_reset();
      test_reset();
      test_left_tap();
      test_right_hold();
      test_reversal();
      test_both();
      test_pause();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
